// File: rtl/reg_bank_dbg_pkg.sv
// reg_bank_dbg_pkg: register indices, status/ctrl bit positions, FSM states and byte-merge helper
package reg_bank_dbg_pkg;
    localparam int REG_IDX_DBG_ADDR    = 0;
    localparam int REG_IDX_DBG_WDATA   = 1;
    localparam int REG_IDX_DBG_CTRL    = 2;
    localparam int VREG_IDX_DBG_STATUS = 0;
    localparam int VREG_IDX_DBG_RDATA  = 1;
    localparam int CTRL_START_WR = 0;
    localparam int CTRL_START_RD = 1;
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    typedef enum logic [1:0] {DBG_IDLE, DBG_REQ, DBG_DONE} dbg_state_e;
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/reg_bank_dbg_access_fsm.sv
// dbg_access_fsm: request/ack debug-memory access engine with status and read-data capture.
// REG_BANK_DBG_TIMEOUT_EN adds an ack-wait timeout that aborts the access after DBG_TIMEOUT cycles.
module dbg_access_fsm
    import reg_bank_dbg_pkg::*;
#(
    parameter int DBG_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        start_wr_i,
    input  logic        start_rd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        i_dbg_ack,
    input  logic [31:0] i_dbg_rdata,
    output logic        o_dbg_req,
    output logic        o_dbg_we,
    output logic [31:0] o_dbg_addr,
    output logic [31:0] o_dbg_wdata,
    output logic [2:0]  status_o,
    output logic [31:0] rdata_o
);
    dbg_state_e  state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef REG_BANK_DBG_TIMEOUT_EN
    localparam int CW = DBG_TIMEOUT > 255 ? $clog2(DBG_TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge i_clk) cnt_q <= (!i_rst_n || state_q != DBG_REQ) ? '0 : cnt_q + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = DBG_TIMEOUT[0];
`endif
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            DBG_IDLE: if (start_wr_i || start_rd_i) begin
                state_d = DBG_REQ;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                we_d    = start_wr_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
            end
            DBG_REQ: if (i_dbg_ack) begin
                state_d = DBG_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rdata_d = we_q ? rdata_q : i_dbg_rdata;
            end
`ifdef REG_BANK_DBG_TIMEOUT_EN
            else if (cnt_q == CW'(DBG_TIMEOUT - 1)) begin
                state_d = DBG_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                rdata_d = '0;
            end
`endif
            default: state_d = DBG_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= DBG_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        status_o = '0;
        status_o[STAT_BUSY] = busy_q;
        status_o[STAT_DONE] = done_q;
        status_o[STAT_ERR]  = err_q;
    end
    assign o_dbg_req   = state_q == DBG_REQ;
    assign o_dbg_we    = we_q;
    assign o_dbg_addr  = addr_q;
    assign o_dbg_wdata = wdata_q;
    assign rdata_o     = rdata_q;
endmodule

// File: rtl/reg_bank_dbg.sv
// reg_bank_dbg: BRAM-port register bank, physical R/W lower half, read-only virtual upper half,
// regs 0..2 drive dbg_access_fsm. Optional timeout via REG_BANK_DBG_TIMEOUT_EN.
module reg_bank_dbg
    import reg_bank_dbg_pkg::*;
#(
    parameter int          N_LOG2      = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DBG_TIMEOUT = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [31:0]                   rd_addr,
    output logic [31:0]                   rd_data,
    input  logic [31:0]                   wr_addr,
    input  logic [7:0]                    wr_be,
    input  logic [31:0]                   wr_data,
    input  logic                          wr_en,
    output logic [32*(1<<N_LOG2)-1:0]     o_phys,
    output logic [(1<<N_LOG2)-1:0]        o_wr_strobe,
    input  logic [32*(1<<N_LOG2)-1:0]     i_virt,
    output logic                          o_dbg_req,
    output logic                          o_dbg_we,
    output logic [31:0]                   o_dbg_addr,
    output logic [31:0]                   o_dbg_wdata,
    input  logic                          i_dbg_ack,
    input  logic [31:0]                   i_dbg_rdata
);
    localparam int N = 1 << N_LOG2;
    logic [31:0]       rd_off, wr_off, virt_v, rd_data_q, rd_data_d, dbg_rdata;
    logic [N_LOG2-1:0] rd_idx, wr_idx;
    logic              rd_hit, rd_virt, wr_hit, wr_virt, wr_sel, start_wr, start_rd;
    logic [2:0]        status;
    logic [32*N-1:0]   phys_q, phys_d;
    logic [N-1:0]      strobe_q, strobe_d;
    logic              unused_ok;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign rd_hit  = rd_off[31:N_LOG2+3] == '0;
    assign wr_hit  = wr_off[31:N_LOG2+3] == '0;
    assign rd_virt = rd_off[N_LOG2+2];
    assign wr_virt = wr_off[N_LOG2+2];
    assign rd_idx  = rd_off[N_LOG2+1:2];
    assign wr_idx  = wr_off[N_LOG2+1:2];
    assign wr_sel  = wr_en && wr_hit && !wr_virt && |wr_be[3:0];
    // CTRL is never stored: its start bits act only in the write cycle
    assign start_wr = wr_sel && wr_idx == N_LOG2'(REG_IDX_DBG_CTRL) && wr_be[0] && wr_data[CTRL_START_WR];
    assign start_rd = wr_sel && wr_idx == N_LOG2'(REG_IDX_DBG_CTRL) && wr_be[0] && wr_data[CTRL_START_RD];
    assign unused_ok = ^{wr_be[7:4], rd_off[1:0], wr_off[1:0]};
    always_comb begin
        phys_d = phys_q;
        if (wr_sel) phys_d[{wr_idx, 5'b0} +: 32] = byte_merge(phys_q[{wr_idx, 5'b0} +: 32], wr_data, wr_be[3:0]);
        phys_d[32*REG_IDX_DBG_CTRL +: 32] = '0;
        strobe_d = wr_sel ? N'(1) << wr_idx : '0;
    end
    always_comb begin
        virt_v = rd_idx == N_LOG2'(VREG_IDX_DBG_STATUS) ? {29'b0, status} :
                 rd_idx == N_LOG2'(VREG_IDX_DBG_RDATA)  ? dbg_rdata : i_virt[{rd_idx, 5'b0} +: 32];
        rd_data_d = !rd_hit ? '0 : rd_virt ? virt_v : phys_q[{rd_idx, 5'b0} +: 32];
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phys_q    <= '0;
            strobe_q  <= '0;
            rd_data_q <= '0;
        end else begin
            phys_q    <= phys_d;
            strobe_q  <= strobe_d;
            rd_data_q <= rd_data_d;
        end
    end
    assign rd_data     = rd_data_q;
    assign o_phys      = phys_q;
    assign o_wr_strobe = strobe_q;
    dbg_access_fsm #(.DBG_TIMEOUT(DBG_TIMEOUT)) u_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .start_wr_i  (start_wr),
        .start_rd_i  (start_rd),
        .addr_i      (phys_q[32*REG_IDX_DBG_ADDR +: 32]),
        .wdata_i     (phys_q[32*REG_IDX_DBG_WDATA +: 32]),
        .i_dbg_ack   (i_dbg_ack),
        .i_dbg_rdata (i_dbg_rdata),
        .o_dbg_req   (o_dbg_req),
        .o_dbg_we    (o_dbg_we),
        .o_dbg_addr  (o_dbg_addr),
        .o_dbg_wdata (o_dbg_wdata),
        .status_o    (status),
        .rdata_o     (dbg_rdata)
    );
endmodule
